room_sequencer: RTL and testbench

//  Sequences the room map generators. Picks which room's mapData reaches the VGA pixel path.

---
 rtl/room_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_room_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/room_sequencer.sv
// Room sequencer: selects which room generator drives the pixel path and runs
// fade-out / room swap / fade-in transitions when the player walks through a doorway.
// Latency: pixel_out is map_data[room_sel] faded by the current level, one cycle later.
// Backpressure: none; busy freezes player movement upstream while a transition runs.
//
// Ports:
//   clk_vga, rst_n              pixel clock, asynchronous active-low reset
//   frame_start                 one-cycle pulse at start of vertical blank
//   player_x, player_y          player position (ignored while busy)
//   map_data0..3                registered RRRGGGBB colour from room generators 0..3
//   pixel_out                   faded colour of the selected room
//   room_sel                    current room index {row,col}
//   busy                        high during FADE_OUT, SWAP and FADE_IN
//   spawn_valid/spawn_x/spawn_y spawn position for the new room, pulsed during SWAP
module room_sequencer #(
  parameter logic [1:0]  START_ROOM  = 2'd0,
  parameter int unsigned FADE_FRAMES = 4,
  parameter int unsigned DOOR_LO     = 260,
  parameter int unsigned DOOR_HI     = 380,
  parameter int unsigned EDGE_N      = 40,
  parameter int unsigned EDGE_S      = 440,
  parameter int unsigned EDGE_W      = 40,
  parameter int unsigned EDGE_E      = 600
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [9:0] player_x,
  input  logic [8:0] player_y,
  input  logic [7:0] map_data0,
  input  logic [7:0] map_data1,
  input  logic [7:0] map_data2,
  input  logic [7:0] map_data3,
  output logic [7:0] pixel_out,
  output logic [1:0] room_sel,
  output logic       busy,
  output logic       spawn_valid,
  output logic [9:0] spawn_x,
  output logic [8:0] spawn_y
);

  // Thresholds sized to the coordinate they are compared against.
  localparam logic [9:0] DOOR_LO_X = 10'(DOOR_LO);
  localparam logic [9:0] DOOR_HI_X = 10'(DOOR_HI);
  localparam logic [8:0] DOOR_LO_Y = 9'(DOOR_LO);
  localparam logic [8:0] DOOR_HI_Y = 9'(DOOR_HI);
  localparam logic [8:0] EDGE_N_Y  = 9'(EDGE_N);
  localparam logic [8:0] EDGE_S_Y  = 9'(EDGE_S);
  localparam logic [9:0] EDGE_W_X  = 10'(EDGE_W);
  localparam logic [9:0] EDGE_E_X  = 10'(EDGE_E);
  localparam logic [3:0] FADE_CNT  = 4'(FADE_FRAMES);

  typedef enum logic [1:0] {PLAY, FADE_OUT, SWAP, FADE_IN} state_t;
  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_W, DIR_E} dir_t;

  state_t     state_q, state_d;
  dir_t       dir_q, dir_d;
  logic [1:0] level_q, level_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] target_q, target_d;
  logic [1:0] room_q, room_d;
  logic [7:0] pixel_q, pixel_d;
  logic [9:0] spawn_x_q, spawn_x_d;
  logic [8:0] spawn_y_q, spawn_y_d;
  logic       spawn_vld;

  // Exit detection against the current room's neighbours.
  logic       row, col;
  logic       x_in_door, y_in_door;
  logic       exit_n, exit_s, exit_w, exit_e;
  logic [3:0] cnt_inc;
  logic       cnt_done;

  assign row       = room_q[1];
  assign col       = room_q[0];
  assign x_in_door = (player_x >= DOOR_LO_X) && (player_x < DOOR_HI_X);
  assign y_in_door = (player_y >= DOOR_LO_Y) && (player_y < DOOR_HI_Y);
  assign exit_n    = (player_y <  EDGE_N_Y) && x_in_door &&  row;
  assign exit_s    = (player_y >= EDGE_S_Y) && x_in_door && !row;
  assign exit_w    = (player_x <  EDGE_W_X) && y_in_door &&  col;
  assign exit_e    = (player_x >= EDGE_E_X) && y_in_door && !col;
  assign cnt_inc   = cnt_q + 4'd1;
  assign cnt_done  = (cnt_inc == FADE_CNT);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    level_d   = level_q;
    cnt_d     = cnt_q;
    target_d  = target_q;
    room_d    = room_q;
    spawn_x_d = spawn_x_q;
    spawn_y_d = spawn_y_q;
    spawn_vld = 1'b0;
    case (state_q)
      PLAY: begin
        if (frame_start && (exit_n || exit_s || exit_w || exit_e)) begin
          state_d = FADE_OUT;
          cnt_d   = 4'd0;
          if (exit_n) begin
            dir_d    = DIR_N;
            target_d = {1'b0, col};
          end else if (exit_s) begin
            dir_d    = DIR_S;
            target_d = {1'b1, col};
          end else if (exit_w) begin
            dir_d    = DIR_W;
            target_d = {row, 1'b0};
          end else begin
            dir_d    = DIR_E;
            target_d = {row, 1'b1};
          end
        end
      end
      FADE_OUT: begin
        if (frame_start) begin
          if (cnt_done) begin
            cnt_d = 4'd0;
            if (level_q == 2'd3) begin
              state_d = SWAP;
              // Load spawn on entry so it is already valid during the SWAP cycle.
              case (dir_q)
                DIR_N:   begin spawn_x_d = 10'd320; spawn_y_d = 9'd400; end
                DIR_S:   begin spawn_x_d = 10'd320; spawn_y_d = 9'd60;  end
                DIR_W:   begin spawn_x_d = 10'd560; spawn_y_d = 9'd240; end
                default: begin spawn_x_d = 10'd80;  spawn_y_d = 9'd240; end
              endcase
            end else begin
              level_d = level_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      SWAP: begin
        // Single cycle; frame_start is deliberately not looked at here.
        room_d    = target_q;
        spawn_vld = 1'b1;
        state_d   = FADE_IN;
      end
      default: begin  // FADE_IN
        if (frame_start) begin
          if (cnt_done) begin
            cnt_d = 4'd0;
            if (level_q == 2'd0) begin
              state_d = PLAY;
            end else begin
              level_d = level_q - 2'd1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
    endcase
  end

  // Per-channel fade of the selected room's colour.
  logic [7:0] sel_pix;
  logic [2:0] fade_r, fade_g;
  logic [1:0] fade_b;

  always_comb begin
    case (room_q)
      2'd0:    sel_pix = map_data0;
      2'd1:    sel_pix = map_data1;
      2'd2:    sel_pix = map_data2;
      default: sel_pix = map_data3;
    endcase
    fade_r  = sel_pix[7:5] >> level_q;
    fade_g  = sel_pix[4:2] >> level_q;
    fade_b  = sel_pix[1:0] >> level_q;
    pixel_d = {fade_r, fade_g, fade_b};
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= PLAY;
      dir_q     <= DIR_N;
      level_q   <= 2'd0;
      cnt_q     <= 4'd0;
      target_q  <= START_ROOM;
      room_q    <= START_ROOM;
      pixel_q   <= 8'h00;
      spawn_x_q <= 10'd320;
      spawn_y_q <= 9'd240;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      room_q    <= room_d;
      pixel_q   <= pixel_d;
      spawn_x_q <= spawn_x_d;
      spawn_y_q <= spawn_y_d;
    end
  end

  assign pixel_out   = pixel_q;
  assign room_sel    = room_q;
  assign busy        = (state_q != PLAY);
  assign spawn_valid = spawn_vld;
  assign spawn_x     = spawn_x_q;
  assign spawn_y     = spawn_y_q;

endmodule

// File: tb/tb_room_sequencer.sv
// Testbench for room_sequencer: scoreboarded pixel and spawn checks across
// reset, doorway boundaries, all four exit directions, retrigger and mid-fade reset.
module tb_room_sequencer;

  logic       clk_vga = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic [7:0] mapv [4];
  logic [7:0] pixel_out;
  logic [1:0] room_sel;
  logic       busy;
  logic       spawn_valid;
  logic [9:0] spawn_x;
  logic [8:0] spawn_y;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  cur_room;
  logic [7:0]  pix_q   [$];
  logic [18:0] spawn_q [$];

  room_sequencer dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .frame_start(frame_start),
    .player_x(player_x), .player_y(player_y),
    .map_data0(mapv[0]), .map_data1(mapv[1]), .map_data2(mapv[2]), .map_data3(mapv[3]),
    .pixel_out(pixel_out), .room_sel(room_sel), .busy(busy),
    .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic logic [7:0] fade_ref(input logic [7:0] c, input int l);
    logic [2:0] r, g;
    logic [1:0] b;
    r = c[7:5] >> l;
    g = c[4:2] >> l;
    b = c[1:0] >> l;
    return {r, g, b};
  endfunction

  // Spawn scoreboard: every spawn_valid cycle must match the next expected spawn.
  always @(negedge clk_vga) begin
    if (rst_n === 1'b1 && spawn_valid === 1'b1) begin
      n_checks++;
      if (spawn_q.size() == 0) begin
        n_fail++;
        $display("FAIL spawn_unexpected: got spawn_valid=1 at (%0d,%0d), required no pulse", spawn_x, spawn_y);
      end else begin
        logic [18:0] e;
        e = spawn_q.pop_front();
        if ({spawn_x, spawn_y} !== e) begin
          n_fail++;
          $display("FAIL spawn_pos: got (%0d,%0d), required (%0d,%0d)", spawn_x, spawn_y, e[18:9], e[8:0]);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic pulse_frame(input int n);
    frame_start = 1'b1;
    repeat (n) @(posedge clk_vga);
    #1 frame_start = 1'b0;
    repeat (3) @(posedge clk_vga);
    #1;
  endtask

  task automatic check_pix(input logic [1:0] room, input int lvl);
    logic [7:0] got, e;
    for (int k = 0; k < 4; k++) mapv[k] = 8'($urandom);
    pix_q.push_back(fade_ref(mapv[room], lvl));
    @(posedge clk_vga); #1;
    e = pix_q.pop_front();
    got = pixel_out;
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL pixel: room %0d level %0d got %h, required %h", room, lvl, got, e);
    end
  endtask

  task automatic check_busy(input logic exp, input string tag);
    n_checks++;
    if (busy !== exp) begin
      n_fail++;
      $display("FAIL busy_%s: got %b, required %b", tag, busy, exp);
    end
  endtask

  task automatic check_room(input logic [1:0] exp, input string tag);
    n_checks++;
    if (room_sel !== exp) begin
      n_fail++;
      $display("FAIL room_%s: got %0d, required %0d", tag, room_sel, exp);
    end
  endtask

  // Caller has placed the player in a valid doorway; the player is moved to
  // (px2,py2) right after the trigger to show that coordinates are ignored while busy.
  task automatic run_transition(input logic [1:0] tgt, input logic [9:0] sx, input logic [8:0] sy,
                                input logic [9:0] px2, input logic [8:0] py2);
    int lvl;
    spawn_q.push_back({sx, sy});
    pulse_frame(1);
    check_busy(1'b1, "trigger");
    player_x = px2;
    player_y = py2;
    for (int i = 1; i <= 16; i++) begin
      // The last fade-out frame is held into the SWAP cycle, where it must be ignored.
      pulse_frame(i == 16 ? 2 : 1);
      lvl = (i / 4 > 3) ? 3 : i / 4;
      check_pix((i == 16) ? tgt : cur_room, lvl);
      check_busy(1'b1, "fade_out");
    end
    check_room(tgt, "swap");
    n_checks++;
    if (spawn_q.size() != 0) begin
      n_fail++;
      $display("FAIL spawn_missing: got %0d pending spawns, required 0", spawn_q.size());
      spawn_q.delete();
    end
    for (int j = 1; j <= 16; j++) begin
      pulse_frame(1);
      lvl = 3 - ((j / 4 > 3) ? 3 : j / 4);
      check_pix(tgt, lvl);
      check_busy(j < 16, "fade_in");
    end
    cur_room = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; player_x = 10'd320; player_y = 9'd240;
    for (int k = 0; k < 4; k++) mapv[k] = 8'h00;
    #12;
    n_checks++;
    if ({pixel_out, room_sel, busy, spawn_valid, spawn_x, spawn_y} !== {8'h00, 2'd0, 1'b0, 1'b0, 10'd320, 9'd240}) begin
      n_fail++;
      $display("FAIL reset_values: got pix=%h room=%0d busy=%b sv=%b spawn=(%0d,%0d), required 00/0/0/0/(320,240)",
               pixel_out, room_sel, busy, spawn_valid, spawn_x, spawn_y);
    end
    @(negedge clk_vga) rst_n = 1'b1;
    @(posedge clk_vga); #1;
    cur_room = 2'd0;
    mapv[0] = 8'hB6;
    pix_q.push_back(8'hB6);
    #1;
    n_checks++;
    if (pixel_out !== 8'h00) begin
      n_fail++;
      $display("FAIL pix_latency: got %h before the clock edge, required 00", pixel_out);
    end
    @(posedge clk_vga); #1;
    n_checks++;
    if (pixel_out !== pix_q[0]) begin
      n_fail++;
      $display("FAIL pix_pass: got %h, required %h", pixel_out, pix_q[0]);
    end
    void'(pix_q.pop_front());
    check_busy(1'b0, "after_reset");
  endtask

  task automatic test_no_exit();
    logic [9:0] xs [6] = '{10'd300, 10'd20,  10'd380, 10'd259, 10'd300, 10'd660};
    logic [8:0] ys [6] = '{9'd20,   9'd300,  9'd450,  9'd450,  9'd439,  9'd380};
    for (int k = 0; k < 6; k++) begin
      player_x = xs[k]; player_y = ys[k];
      pulse_frame(1);
      check_busy(1'b0, "no_exit");
      check_room(2'd0, "no_exit");
    end
    player_x = 10'd300; player_y = 9'd450;
    repeat (6) @(posedge clk_vga);
    #1;
    check_busy(1'b0, "no_frame_start");
  endtask

  task automatic test_south_exit();
    player_x = 10'd260; player_y = 9'd440;
    run_transition(2'd2, 10'd320, 9'd60, 10'd300, 9'd20);
  endtask

  task automatic test_retrigger();
    // Player already sits in room 2's north doorway; first PLAY frame triggers.
    check_busy(1'b0, "before_retrigger");
    run_transition(2'd0, 10'd320, 9'd400, 10'd320, 9'd240);
  endtask

  task automatic test_back_to_back();
    player_x = 10'd620; player_y = 9'd300;
    run_transition(2'd1, 10'd80, 9'd240, 10'd80, 9'd240);
    player_x = 10'd379; player_y = 9'd450;
    run_transition(2'd3, 10'd320, 9'd60, 10'd320, 9'd60);
  endtask

  task automatic test_north_priority();
    player_x = 10'd20; player_y = 9'd20;
    pulse_frame(1);
    check_busy(1'b0, "corner");
    player_x = 10'd300; player_y = 9'd20;
    run_transition(2'd1, 10'd320, 9'd400, 10'd320, 9'd400);
    player_x = 10'd20; player_y = 9'd300;
    run_transition(2'd0, 10'd560, 9'd240, 10'd560, 9'd240);
  endtask

  task automatic test_reset_mid();
    player_x = 10'd300; player_y = 9'd450;
    pulse_frame(1);
    player_x = 10'd320; player_y = 9'd240;
    for (int i = 1; i <= 8; i++) pulse_frame(1);
    check_pix(2'd0, 2);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pixel_out, room_sel, busy, spawn_valid, spawn_x, spawn_y} !== {8'h00, 2'd0, 1'b0, 1'b0, 10'd320, 9'd240}) begin
      n_fail++;
      $display("FAIL reset_mid: got pix=%h room=%0d busy=%b sv=%b spawn=(%0d,%0d), required 00/0/0/0/(320,240)",
               pixel_out, room_sel, busy, spawn_valid, spawn_x, spawn_y);
    end
    repeat (3) @(posedge clk_vga);
    @(negedge clk_vga) rst_n = 1'b1;
    cur_room = 2'd0;
    pulse_frame(1);
    check_busy(1'b0, "after_reset_mid");
    check_pix(2'd0, 0);
  endtask

  initial begin
    test_reset();
    test_no_exit();
    test_south_exit();
    test_retrigger();
    test_back_to_back();
    test_north_priority();
    test_reset_mid();
    repeat (4) @(posedge clk_vga);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
